// File: rtl/fc_ifmap_pp_buf_pkg.sv
// Shared defaults and bank state type for the FC ifmap ping-pong buffer.
package fc_pkg;
  localparam int FC_DATA_W      = 8;
  localparam int FC_IFMAP_DEPTH = 1024;
  localparam int FC_IFMAP_LANES = 4;

  typedef enum logic {BANK_FREE, BANK_FULL} bank_state_e;
endpackage

// File: rtl/fc_ifmap_pp_buf_if.sv
// Loader/reader-facing bus of the ifmap ping-pong buffer; master is the client side.
interface fc_ifmap_pp_buf_if import fc_pkg::*; #(
  parameter int DATA_W = FC_DATA_W,
  parameter int DEPTH  = FC_IFMAP_DEPTH,
  parameter int LANES  = FC_IFMAP_LANES
);
  localparam int AW = $clog2(DEPTH);

  logic                    wren_i;
  logic [AW-1:0]           wrptr_i;
  logic [DATA_W-1:0]       ifmap_i;
  logic                    wr_done_i;
  logic                    wr_ready_o;
  logic                    rden_i;
  logic [AW-1:0]           rdptr_i;
  logic [LANES*DATA_W-1:0] ifmap_o;
  logic                    rd_valid_o;
  logic                    rd_ready_o;
  logic [AW:0]             len_o;
  logic                    rd_done_i;

  modport master (
    output wren_i, wrptr_i, ifmap_i, wr_done_i, rden_i, rdptr_i, rd_done_i,
    input  wr_ready_o, ifmap_o, rd_valid_o, rd_ready_o, len_o
  );

  modport slave (
    input  wren_i, wrptr_i, ifmap_i, wr_done_i, rden_i, rdptr_i, rd_done_i,
    output wr_ready_o, ifmap_o, rd_valid_o, rd_ready_o, len_o
  );
endinterface

// File: rtl/fc_ifmap_bank.sv
// One ifmap bank: LANES narrow simple-dual-port RAMs, element-wide write, LANES-wide registered read.
module fc_ifmap_bank import fc_pkg::*; #(
  parameter int DATA_W = FC_DATA_W,
  parameter int DEPTH  = FC_IFMAP_DEPTH,
  parameter int LANES  = FC_IFMAP_LANES
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [LANES*DATA_W-1:0] rd_data
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LB    = $clog2(LANES);
  localparam int WORDS = DEPTH / LANES;

  logic [AW-1:0] wr_word;
  logic [AW-1:0] rd_word;
  logic [AW-1:0] wr_lane;

  assign wr_word = wr_addr >> LB;
  assign rd_word = rd_addr >> LB;
  assign wr_lane = wr_addr & AW'(LANES - 1);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [DATA_W-1:0] mem [WORDS];
    logic signed [DATA_W-1:0] q_p1;

    // Stage p0 -> p1: write port and registered read port; q_p1 holds between reads.
    always_ff @(posedge clk) begin
      if (wr_en && (wr_lane == AW'(k))) mem[wr_word] <= wr_data;
      if (rd_en) q_p1 <= mem[rd_word];
    end

    assign rd_data[k*DATA_W +: DATA_W] = q_p1;
  end
endmodule

// File: rtl/fc_ifmap_pp_buf.sv
// Ping-pong ifmap buffer for the FC layer: per-bank FREE/FULL handshake, lane-wide reads with tail padding.
module fc_ifmap_pp_buf import fc_pkg::*; #(
  parameter int DATA_W = FC_DATA_W,
  parameter int DEPTH  = FC_IFMAP_DEPTH,
  parameter int LANES  = FC_IFMAP_LANES
) (
  input logic clk,
  input logic rst,
  fc_ifmap_pp_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = LANES * DATA_W;

  bank_state_e      st [2];
  bank_state_e      st_n [2];
  logic             wr_bank, rd_bank;
  logic             wr_ready, rd_ready;
  logic [AW:0]      fill_len, fill_len_n;
  logic [AW:0]      len_q [2];
  logic [AW:0]      len_n [2];
  logic [AW:0]      len_r;
  logic             wr_fire, commit, rd_fire, rel;
  logic [AW-1:0]    rd_base;
  logic [LANES-1:0] mask_n, mask_p1;
  logic             sel_p1, vld_p1;
  logic [WW-1:0]    rdata [2];

  always_comb begin
    wr_fire = bus.wren_i & wr_ready;
    commit  = bus.wr_done_i & wr_ready;
    rd_fire = bus.rden_i & rd_ready;
    rel     = bus.rd_done_i & rd_ready;

    // A write landing in the commit cycle still counts towards the committed length.
    fill_len_n = fill_len;
    if (wr_fire && ({1'b0, bus.wrptr_i} >= fill_len))
      fill_len_n = {1'b0, bus.wrptr_i} + 1'b1;

    st_n  = st;
    len_n = len_q;
    if (commit) begin
      st_n[wr_bank]  = BANK_FULL;
      len_n[wr_bank] = fill_len_n;
    end
    if (rel) st_n[rd_bank] = BANK_FREE;

    rd_base = bus.rdptr_i & ~AW'(LANES - 1);
    for (int k = 0; k < LANES; k++)
      mask_n[k] = (({1'b0, rd_base} + (AW+1)'(k)) < len_r);
  end

  // Stage p0 -> p1: bank state, pointers, handshake flags and the read-side mask/select.
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]    <= BANK_FREE;
      st[1]    <= BANK_FREE;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_ready <= 1'b1;
      rd_ready <= 1'b0;
      fill_len <= '0;
      len_q[0] <= '0;
      len_q[1] <= '0;
      len_r    <= '0;
      vld_p1   <= 1'b0;
      mask_p1  <= '0;
      sel_p1   <= 1'b0;
    end else begin
      st       <= st_n;
      wr_bank  <= wr_bank ^ commit;
      rd_bank  <= rd_bank ^ rel;
      wr_ready <= (st_n[wr_bank ^ commit] == BANK_FREE);
      rd_ready <= (st_n[rd_bank ^ rel] == BANK_FULL);
      fill_len <= commit ? '0 : fill_len_n;
      len_q    <= len_n;
      len_r    <= len_n[rd_bank ^ rel];
      vld_p1   <= rd_fire;
      if (rd_fire) begin
        mask_p1 <= mask_n;
        sel_p1  <= rd_bank;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fc_ifmap_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) u_bank (
      .clk     (clk),
      .wr_en   (wr_fire && (wr_bank == 1'(b))),
      .wr_addr (bus.wrptr_i),
      .wr_data (bus.ifmap_i),
      .rd_en   (rd_fire && (rd_bank == 1'(b))),
      .rd_addr (bus.rdptr_i),
      .rd_data (rdata[b])
    );
  end

  // Mask and select only move on an accepted read, so ifmap_o holds between reads.
  always_comb begin
    bus.ifmap_o = '0;
    for (int k = 0; k < LANES; k++)
      bus.ifmap_o[k*DATA_W +: DATA_W] = mask_p1[k] ? rdata[sel_p1][k*DATA_W +: DATA_W] : '0;
  end

  assign bus.wr_ready_o = wr_ready;
  assign bus.rd_ready_o = rd_ready;
  assign bus.rd_valid_o = vld_p1;
  assign bus.len_o      = len_r;
endmodule

// File: tb/tb_fc_ifmap_pp_buf.sv
// Bench for fc_ifmap_pp_buf: directed scenarios plus random traffic against a two-entry buffer-queue model.
module tb_fc_ifmap_pp_buf;
  localparam int DW    = 8;
  localparam int DEPTH = 64;
  localparam int LANES = 4;
  localparam int AW    = 6;
  localparam int WW    = LANES * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_ifmap_pp_buf_if #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES)) bus ();
  fc_ifmap_pp_buf #(.DATA_W(DW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: the buffer is a queue of at most two committed ifmaps plus one ifmap being filled.
  logic [DW-1:0] f_data [DEPTH];
  int            f_len;
  logic [DW-1:0] q_data [2][DEPTH];
  int            q_len  [2];
  int            q_head, q_cnt;
  logic [WW-1:0] exp_word;
  logic          exp_vld;

  int s_n, s_pos;
  int perm [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.wren_i    = 1'b0;
    bus.wrptr_i   = '0;
    bus.ifmap_i   = '0;
    bus.wr_done_i = 1'b0;
    bus.rden_i    = 1'b0;
    bus.rdptr_i   = '0;
    bus.rd_done_i = 1'b0;
  endtask

  task automatic tick();
    bit wr_ok, rd_ok, push, pop;
    int tail;
    wr_ok = (q_cnt < 2);
    rd_ok = (q_cnt > 0);
    if (rst) begin
      q_cnt = 0; q_head = 0; f_len = 0;
      exp_vld = 1'b0; exp_word = '0;
    end else begin
      exp_vld = bus.rden_i && rd_ok;
      if (exp_vld)
        for (int k = 0; k < LANES; k++) begin
          int a;
          a = (int'(bus.rdptr_i) / LANES) * LANES + k;
          exp_word[k*DW +: DW] = (a < q_len[q_head]) ? q_data[q_head][a] : '0;
        end
      if (bus.wren_i && wr_ok) begin
        f_data[bus.wrptr_i] = bus.ifmap_i;
        if (int'(bus.wrptr_i) >= f_len) f_len = int'(bus.wrptr_i) + 1;
      end
      push = bus.wr_done_i && wr_ok;
      pop  = bus.rd_done_i && rd_ok;
      if (push) begin
        tail = (q_head + q_cnt) % 2;
        q_data[tail] = f_data;
        q_len[tail]  = f_len;
        f_len = 0;
      end
      if (pop) q_head = (q_head + 1) % 2;
      q_cnt = q_cnt + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
    check("wr_ready", bus.wr_ready_o, q_cnt < 2);
    check("rd_ready", bus.rd_ready_o, q_cnt > 0);
    check("rd_valid", bus.rd_valid_o, exp_vld);
    check("ifmap", bus.ifmap_o, exp_word);
    if (rst) check("len_rst", bus.len_o, 0);
    else if (q_cnt > 0) check("len", bus.len_o, q_len[q_head]);
  endtask

  task automatic fill(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      bus.wren_i  = 1'b1;
      bus.wrptr_i = AW'(k);
      bus.ifmap_i = DW'(base + k);
      tick();
    end
    bus.wren_i = 1'b0;
  endtask

  task automatic pulse_wr_done();
    bus.wr_done_i = 1'b1; tick(); bus.wr_done_i = 1'b0;
  endtask

  task automatic pulse_rd_done();
    bus.rd_done_i = 1'b1; tick(); bus.rd_done_i = 1'b0;
  endtask

  task automatic read(input int ptr);
    bus.rden_i = 1'b1; bus.rdptr_i = AW'(ptr); tick(); bus.rden_i = 1'b0;
  endtask

  task automatic new_session();
    int j, t;
    s_n   = $urandom_range(0, DEPTH);
    s_pos = 0;
    for (int k = 0; k < DEPTH; k++) perm[k] = k;
    for (int k = s_n - 1; k > 0; k--) begin
      j = $urandom_range(0, k);
      t = perm[k]; perm[k] = perm[j]; perm[j] = t;
    end
  endtask

  initial begin
    idle();
    q_cnt = 0; q_head = 0; f_len = 0; exp_vld = 1'b0; exp_word = '0;
    q_len[0] = 0; q_len[1] = 0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();

    fill(16, 0);
    pulse_wr_done();
    check("d1_rd_ready", bus.rd_ready_o, 1);
    check("d1_len", bus.len_o, 16);
    read(4);
    check("d1_word", bus.ifmap_o, 32'h07060504);
    check("d1_vld", bus.rd_valid_o, 1);
    pulse_rd_done();

    fill(10, 8'h10);
    pulse_wr_done();
    read(8);
    check("d2_pad_word", bus.ifmap_o, 32'h00001918);
    pulse_rd_done();

    pulse_wr_done();
    check("d3_empty_len", bus.len_o, 0);
    read(0);
    check("d3_empty_word", bus.ifmap_o, 0);
    bus.rden_i = 1'b1; bus.rd_done_i = 1'b1; tick(); idle();
    check("d4_rd_ready_after_release", bus.rd_ready_o, 0);
    read(0);
    check("d4_no_valid", bus.rd_valid_o, 0);

    fill(4, 8'h40);
    pulse_wr_done();
    bus.rden_i = 1'b1; rst = 1'b1; tick(); idle();
    rst = 1'b0;
    check("d5_rst_vld", bus.rd_valid_o, 0);
    check("d5_rst_len", bus.len_o, 0);
    check("d5_rst_wr_ready", bus.wr_ready_o, 1);

    new_session();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      idle();
      rst = ($urandom_range(0, 599) == 0);
      if (s_pos < s_n) begin
        if ($urandom_range(0, 3) != 0) begin
          if (q_cnt < 2) begin
            bus.wren_i  = 1'b1;
            bus.wrptr_i = AW'(perm[s_pos]);
            bus.ifmap_i = DW'($urandom);
            s_pos++;
          end else if ($urandom_range(0, 1) == 0) begin
            bus.wren_i  = 1'b1;
            bus.wrptr_i = AW'($urandom);
            bus.ifmap_i = DW'($urandom);
          end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        bus.wr_done_i = 1'b1;
        if (q_cnt < 2) new_session();
      end
      bus.rden_i    = ($urandom_range(0, 1) == 0);
      bus.rdptr_i   = AW'($urandom);
      bus.rd_done_i = ($urandom_range(0, 11) == 0);
      if (rst) new_session();
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_ifmap_pp_buf.md
# fc_ifmap_pp_buf

Parametrised ping-pong input-feature-map buffer for the fully-connected layer. Two banks of DEPTH elements: the loader fills one while the FC datapath reads LANES elements per cycle from the other. A per-bank FREE/FULL handshake replaces the single-bank buffer's free-running pointers. Sits between the ifmap DMA/loader and the FC PE array.

## Interface
- DATA_W, 8, element width in bits (signed ifmap byte by default)
- DEPTH, 1024, elements per bank; power of two
- LANES, 4, elements returned per read; power of two, divides DEPTH
- AW, $clog2(DEPTH), element address width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wren_i  in  1  write one element into the current write bank
- wrptr_i  in  AW  element address of the write
- ifmap_i  in  DATA_W  write data
- wr_done_i  in  1  current write bank complete; commit and swap
- wr_ready_o  out  1  current write bank is FREE; writes accepted
- rden_i  in  1  read request on the current read bank
- rdptr_i  in  AW  element address, must be LANES-aligned
- ifmap_o  out  LANES*DATA_W  lane k = element rdptr_i+k, lane 0 in LSBs
- rd_valid_o  out  1  ifmap_o valid this cycle
- rd_ready_o  out  1  current read bank is FULL; reads accepted
- len_o  out  AW+1  committed element count of the current read bank
- rd_done_i  in  1  reader finished with bank; release and swap

## Operation
- State per bank: FREE or FULL. wr_bank and rd_bank are 1-bit pointers.
- Reset: both banks FREE, wr_bank=rd_bank=0, wr_ready_o=1, rd_ready_o=0, rd_valid_o=0, ifmap_o=0, len_o=0. RAM contents are not cleared.
- Write:
  - wren_i && wr_ready_o stores ifmap_i at wrptr_i in wr_bank.
  - The fill length register tracks max(wrptr_i)+1 over the fill and clears on swap.
  - wren_i while !wr_ready_o is dropped.
- wr_done_i && wr_ready_o:
  - Marks wr_bank FULL, latches its length (0 if nothing was written) and toggles wr_bank.
  - A write in the same cycle is included, and so is its address in the length.
  - wr_done_i while !wr_ready_o is ignored.
- Read:
  - rden_i && rd_ready_o reads word rdptr_i[AW-1:log2 LANES] of rd_bank.
  - Lanes whose element address is >= len_o return 0 (tail padding for the FC dot product).
  - rden_i while !rd_ready_o gives rd_valid_o=0 next cycle.
  - rdptr_i low bits are ignored (treated as aligned).
- rd_done_i && rd_ready_o marks rd_bank FREE and toggles rd_bank. A read issued in the same cycle still completes from the old bank.
- Simultaneous wr_done_i and rd_done_i on different banks: both take effect and there is no lost state.
- Invariant: the writer never enters a FULL bank and the reader never enters a FREE bank.

## Timing
- Write: registered in the cycle wren_i is sampled. It can be read back through the other pointer only after the commit.
- Read latency is 1 cycle: rden_i at cycle N gives ifmap_o/rd_valid_o at N+1. Back-to-back reads give 1 word per cycle.
- ifmap_o holds its last value when rd_valid_o=0.
- wr_ready_o and rd_ready_o are registered and update the cycle after wr_done_i/rd_done_i.
- Commit-to-read: wr_done_i at N makes rd_ready_o=1 at N+1 (if rd_bank == committed bank).
- Release-to-write: rd_done_i at N makes wr_ready_o=1 at N+1.
- len_o is valid whenever rd_ready_o=1.
- rst asserted mid-operation: all state returns to reset values on the next edge, and an in-flight read's rd_valid_o is forced to 0.

## Structure
- Package fc_pkg:
  - FC_DATA_W, FC_IFMAP_DEPTH and FC_IFMAP_LANES defaults.
  - typedef enum logic {BANK_FREE, BANK_FULL} bank_state_e.
- Sub-module fc_ifmap_bank:
  - One bank as LANES narrow simple-dual-port RAMs (DEPTH/LANES × DATA_W each).
  - Lane write-select from wrptr_i low bits; registered read.
  - Instantiated twice.
- Top level holds the bank state, pointers, length registers and padding mask.

## Test plan
- Reset, fill bank 0 with addr k → data k for k=0..15, wr_done_i → rd_ready_o=1 next cycle, len_o=16. Read rdptr=4 → ifmap_o lanes {4,5,6,7}, rd_valid_o one cycle later.
- Fill 10 elements, read rdptr=8 → lanes {8,9,0,0} (padding beyond len_o=10). wr_done_i with no writes → len_o=0, all lanes 0.
- Ping-pong:
  - Commit bank 0, fill bank 1 while reading bank 0.
  - Commit bank 1 → wr_ready_o=0, and writes are dropped (bank 0 readback unchanged).
  - rd_done_i → wr_ready_o=1 next cycle, rd_ready_o stays 1 with bank 1 data.
- Same-cycle: wr_done_i (bank 1) and rd_done_i (bank 0) together → both banks' states update, no deadlock, and the next read returns bank 1 data.
- Same-cycle: rden_i and rd_done_i → old-bank data returned, rd_ready_o=0 afterwards if the other bank is FREE. rden_i while rd_ready_o=0 → rd_valid_o=0.
- Assert rst mid-fill and mid-read → wr_ready_o=1, rd_ready_o=0, rd_valid_o=0, len_o=0 next cycle. A new fill/read then works normally.
